// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// csa_accumulator
//
// Multi-operand accumulator that keeps its running total in carry-save form.
// This keeps every accumulate cycle one full-adder level deep, whatever WIDTH
// is. When the last beat of a packet arrives, the sum/carry pair is resolved
// into a binary result. The resolve pass is a chunked carry-propagate adder
// that handles CHUNK bits per cycle, LSB chunk first. The result is then
// offered on a valid/ready output.
//
// Parameters
//   WIDTH     accumulator / result width in bits
//   IN_WIDTH  operand width (<= WIDTH); operands are zero-extended
//   CHUNK     bits resolved per cycle; WIDTH must be a multiple of CHUNK
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      operand beat valid
//   in_ready      block accepts an operand (high only while accumulating)
//   in_data       unsigned operand
//   in_last       final operand of the packet, qualified by in_valid&in_ready
//   out_valid     resolved result valid
//   out_ready     consumer accepts the result
//   out_data      packet sum modulo 2^WIDTH
//   out_overflow  true packet sum >= 2^WIDTH
//   busy          high while resolving or presenting a result
// ---------------------------------------------------------------------------
module csa_accumulator #(
    parameter int WIDTH    = 16,
    parameter int IN_WIDTH = 8,
    parameter int CHUNK    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_overflow,
    output logic                busy
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_ACC     = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] c_reg;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic [CW-1:0]    chunk_cnt;
    logic             carry;

    // Handshake qualifiers
    logic in_fire;
    logic out_fire;
    logic last_chunk;

    assign in_fire    = in_valid && (state == ST_ACC);
    assign out_fire   = out_ready && (state == ST_OUTPUT);
    assign last_chunk = (chunk_cnt == LAST_CHUNK);

    // ------------------------------------------------------------------
    // Carry-save update: one full-adder row across the word.
    // The majority bit that falls off the top is a real 2^WIDTH
    // contribution. It is recorded in the sticky overflow flag instead of
    // being carried.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] x_ext;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] maj;
    logic [WIDTH-1:0] c_next;

    assign x_ext  = WIDTH'(in_data);
    assign s_next = s_reg ^ c_reg ^ x_ext;
    assign maj    = (s_reg & c_reg) | (s_reg & x_ext) | (c_reg & x_ext);
    assign c_next = {maj[WIDTH-2:0], 1'b0};

    // ------------------------------------------------------------------
    // Resolve step: add one CHUNK-wide slice of sum and carry, plus the
    // carry rippled in from the previous slice.
    // ------------------------------------------------------------------
    logic [CHUNK-1:0] s_chunk;
    logic [CHUNK-1:0] c_chunk;
    logic [CHUNK:0]   chunk_sum;

    assign s_chunk   = s_reg[chunk_cnt*CHUNK +: CHUNK];
    assign c_chunk   = c_reg[chunk_cnt*CHUNK +: CHUNK];
    assign chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, carry};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values no matter the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_next receives a default before the case statement. This
    // means no path leaves it unassigned, and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACC: begin
                if (in_fire && in_last) begin
                    state_next = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                if (last_chunk) begin
                    state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_fire) begin
                    state_next = ST_ACC;
                end
            end
            default: begin
                state_next = ST_ACC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg     <= '0;
            c_reg     <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            chunk_cnt <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_fire) begin
                        s_reg <= s_next;
                        c_reg <= c_next;
                        if (maj[WIDTH-1]) begin
                            overflow <= 1'b1;
                        end
                        if (in_last) begin
                            chunk_cnt <= '0;
                            carry     <= 1'b0;
                        end
                    end
                end
                ST_RESOLVE: begin
                    result[chunk_cnt*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry <= chunk_sum[CHUNK];
                    if (last_chunk) begin
                        // A carry out of the top slice is also a 2^WIDTH term
                        overflow  <= overflow | chunk_sum[CHUNK];
                        chunk_cnt <= '0;
                    end else begin
                        chunk_cnt <= chunk_cnt + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    // result is kept so out_data persists after the handshake
                    if (out_fire) begin
                        s_reg    <= '0;
                        c_reg    <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                    s_reg <= s_reg;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready     = (state == ST_ACC);
    assign out_valid    = (state == ST_OUTPUT);
    assign busy         = (state != ST_ACC);
    assign out_data     = result;
    assign out_overflow = overflow;

endmodule

// File: tb/tb_csa_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_accumulator
//
// Directed testbench for csa_accumulator with its default parameters
// (WIDTH=16, IN_WIDTH=8, CHUNK=4). Every expected value is hand-computed.
// Inputs are driven on the falling edge. Outputs are sampled 1ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_csa_accumulator;

    localparam int WIDTH    = 16;
    localparam int IN_WIDTH = 8;
    localparam int CHUNK    = 4;
    localparam int NCH      = WIDTH / CHUNK;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [IN_WIDTH-1:0] in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic                out_overflow;
    logic                busy;

    int errors;
    int checks;

    csa_accumulator #(
        .WIDTH   (WIDTH),
        .IN_WIDTH(IN_WIDTH),
        .CHUNK   (CHUNK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_overflow(out_overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Send one beat after `gap` idle cycles. The task returns 1ns after the
    // rising edge that accepted the beat. timeout is set if in_ready never
    // came.
    task automatic send(input logic [IN_WIDTH-1:0] d, input bit last, input int gap,
                        output bit timeout);
        int n;
        timeout = 1'b0;
        for (int i = 0; i < gap; i++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Count rising edges until out_valid is seen (bounded).
    task automatic wait_result(output int lat, output bit timeout);
        lat     = 0;
        timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (out_data !== 16'h0000 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: out_data=%h ovf=%b want 0000 0", out_data, out_overflow);
        end
    endtask

    // 1+2+3+4+5 = 15; checks the NCH-edge latency and the one-cycle out_valid.
    task automatic test_basic_sum;
        bit to;
        int lat;
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            send(IN_WIDTH'(i), (i == 5), 0, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL basic_send: beat %0d not accepted", i);
            end
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        wait_result(lat, to);
        checks++;
        if (to || lat != NCH) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges (timeout=%b) want %0d", lat, to, NCH);
        end
        checks++;
        if (out_data !== 16'h000F || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_data: out_data=%h ovf=%b want 000f 0", out_data, out_overflow);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_pulse: out_valid=%b in_ready=%b after handshake want 0 1",
                     out_valid, in_ready);
        end
    endtask

    // 0xFF + 0x01 = 0x100, which forces a carry ripple across the chunks.
    task automatic test_carry_ripple;
        bit to;
        int lat;
        send(8'hFF, 1'b0, 0, to);
        send(8'h01, 1'b1, 0, to);
        wait_result(lat, to);
        checks++;
        if (to || out_data !== 16'h0100 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ripple: out_data=%h ovf=%b timeout=%b want 0100 0",
                     out_data, out_overflow, to);
        end
        @(posedge clk);
        #1;
    endtask

    // 300 * 0xFF = 76500 = 65536 + 0x2AD4
    task automatic test_overflow;
        bit to;
        int lat;
        for (int i = 0; i < 300; i++) send(8'hFF, (i == 299), 0, to);
        wait_result(lat, to);
        checks++;
        if (to || out_data !== 16'h2AD4 || out_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow300: out_data=%h ovf=%b timeout=%b want 2ad4 1",
                     out_data, out_overflow, to);
        end
        @(posedge clk);
        #1;
    endtask

    // 257 * 0xFF + 1 = 65536 exactly -> data 0, overflow set
    task automatic test_exact_wrap;
        bit to;
        int lat;
        for (int i = 0; i < 257; i++) send(8'hFF, 1'b0, 0, to);
        send(8'h01, 1'b1, 0, to);
        wait_result(lat, to);
        checks++;
        if (to || out_data !== 16'h0000 || out_overflow !== 1'b1) begin
            errors++;
            $display("FAIL exact_wrap: out_data=%h ovf=%b timeout=%b want 0000 1",
                     out_data, out_overflow, to);
        end
        @(posedge clk);
        #1;
    endtask

    // Single beat 0xA5 with the consumer stalling for 3 cycles
    task automatic test_backpressure;
        bit to;
        int lat;
        int bad;
        out_ready = 1'b0;
        send(8'hA5, 1'b1, 0, to);
        wait_result(lat, to);
        checks++;
        if (to || out_data !== 16'h00A5 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL stall_data: out_data=%h ovf=%b timeout=%b want 00a5 0",
                     out_data, out_overflow, to);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== 16'h00A5 || in_ready !== 1'b0 || busy !== 1'b1)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d stalled cycles unstable, last out_valid=%b data=%h in_ready=%b busy=%b",
                     bad, out_valid, out_data, in_ready, busy);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 16'h00A5) begin
            errors++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b busy=%b data=%h want 0 1 0 00a5",
                     out_valid, in_ready, busy, out_data);
        end
    endtask

    // {7,9} then {0x10}, with random idle gaps between the beats
    task automatic test_back_to_back;
        bit to;
        int lat;
        send(8'h07, 1'b0, $urandom_range(0, 3), to);
        send(8'h09, 1'b1, $urandom_range(0, 3), to);
        wait_result(lat, to);
        checks++;
        if (to || out_data !== 16'h0010 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: out_data=%h ovf=%b timeout=%b want 0010 0",
                     out_data, out_overflow, to);
        end
        @(posedge clk);
        #1;
        send(8'h10, 1'b1, $urandom_range(0, 3), to);
        wait_result(lat, to);
        checks++;
        if (to || out_data !== 16'h0010 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: out_data=%h ovf=%b timeout=%b want 0010 0",
                     out_data, out_overflow, to);
        end
        @(posedge clk);
        #1;
    endtask

    // Async reset in the middle of RESOLVE for {0x80,0x80}, then packet {3}
    task automatic test_mid_reset;
        bit to;
        int lat;
        int pulses;
        send(8'h80, 1'b0, 0, to);
        send(8'h80, 1'b1, 0, to);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_data !== 16'h0000 || out_overflow !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_async: data=%h ovf=%b out_valid=%b busy=%b in_ready=%b want 0000 0 0 0 1",
                     out_data, out_overflow, out_valid, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midreset_pulse: out_valid seen %0d cycles want 0", pulses);
        end
        send(8'h03, 1'b1, 0, to);
        wait_result(lat, to);
        checks++;
        if (to || out_data !== 16'h0003 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next: out_data=%h ovf=%b timeout=%b want 0003 0",
                     out_data, out_overflow, to);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic_sum();
        test_carry_ripple();
        test_overflow();
        test_exact_wrap();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
